// File: rtl/mm_tile_sequencer_if.sv
// mm_tile_sequencer_if -- run handshake and operand-read bus of the tile sequencer; rev 1.0
// cycle_count is present only when MM_SEQ_CYCLE_CNT_EN is defined.
`default_nettype none

interface mm_tile_sequencer_if #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int K  = 8,
    parameter int P  = 8
);
    localparam int AW_A = ($clog2(M*K/N1) == 0) ? 1 : $clog2(M*K/N1);
    localparam int AW_B = ($clog2(K*P/N2) == 0) ? 1 : $clog2(K*P/N2);
    localparam int RW   = ($clog2(M/N1) == 0) ? 1 : $clog2(M/N1);
    localparam int CW   = ($clog2(P/N2) == 0) ? 1 : $clog2(P/N2);

    logic            start;
    logic            stall;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [AW_A-1:0] rd_addr_A;
    logic [AW_B-1:0] rd_addr_B;
    logic            acc_clear;
    logic            k_last;
    logic [RW-1:0]   tile_row;
    logic [CW-1:0]   tile_col;
    logic            tile_done;
`ifdef MM_SEQ_CYCLE_CNT_EN
    logic [31:0]     cycle_count;

    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_A, rd_addr_B, acc_clear, k_last,
               tile_row, tile_col, tile_done, cycle_count
    );
    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_A, rd_addr_B, acc_clear, k_last,
               tile_row, tile_col, tile_done, cycle_count
    );
`else
    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_A, rd_addr_B, acc_clear, k_last,
               tile_row, tile_col, tile_done
    );
    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_A, rd_addr_B, acc_clear, k_last,
               tile_row, tile_col, tile_done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer -- tiled A/B read-address sequencer with run handshake and drain; rev 1.0
// Define MM_SEQ_CYCLE_CNT_EN to add the 32-bit busy-cycle counter output.
`default_nettype none

module mm_tile_sequencer #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8,
    parameter int K  = 8,
    parameter int P  = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mm_tile_sequencer_if.master     bus
);
    localparam int TR    = M / N1;
    localparam int TC    = P / N2;
    localparam int DRAIN = N1 + N2;
    localparam int AW_A  = ($clog2(M*K/N1) == 0) ? 1 : $clog2(M*K/N1);
    localparam int AW_B  = ($clog2(K*P/N2) == 0) ? 1 : $clog2(K*P/N2);
    localparam int KW    = ($clog2(K) == 0) ? 1 : $clog2(K);
    localparam int DW    = ($clog2(DRAIN) == 0) ? 1 : $clog2(DRAIN);
    localparam int RW    = ($clog2(TR) == 0) ? 1 : $clog2(TR);
    localparam int CW    = ($clog2(TC) == 0) ? 1 : $clog2(TC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            hold;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic            acc_clear_q, acc_clear_d;
    logic            k_last_q, k_last_d;
    logic            tile_done_q, tile_done_d;
    logic [AW_A-1:0] addr_a_q, addr_a_d;
    logic [AW_B-1:0] addr_b_q, addr_b_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        row_d   = row_q;
        col_d   = col_q;
        hold    = bus.stall && (state_q != S_IDLE);

        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_FEED;
                        k_d     = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
                S_FEED: begin
                    if (k_q == KW'(K-1)) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == DW'(DRAIN-1)) begin
                        // The final tile index is kept so it stays visible until the next start.
                        if (row_q == RW'(TR-1) && col_q == CW'(TC-1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FEED;
                            k_d     = '0;
                            if (col_q == CW'(TC-1)) begin
                                col_d = '0;
                                row_d = row_q + RW'(1);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with the step being presented.
        busy_d      = (state_d == S_FEED) || (state_d == S_DRAIN);
        rd_en_d     = !hold && (state_d == S_FEED);
        acc_clear_d = rd_en_d && (k_d == '0);
        k_last_d    = rd_en_d && (k_d == KW'(K-1));
        tile_done_d = !hold && (state_d == S_DRAIN) && (dcnt_d == DW'(DRAIN-1));
        done_d      = !hold && (state_d == S_DONE);
        addr_a_d    = AW_A'(K * int'(row_d) + int'(k_d));
        addr_b_d    = AW_B'(K * int'(col_d) + int'(k_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            dcnt_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_clear_q <= 1'b0;
            k_last_q    <= 1'b0;
            tile_done_q <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            acc_clear_q <= acc_clear_d;
            k_last_q    <= k_last_d;
            tile_done_q <= tile_done_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_A = addr_a_q;
    assign bus.rd_addr_B = addr_b_q;
    assign bus.acc_clear = acc_clear_q;
    assign bus.k_last    = k_last_q;
    assign bus.tile_row  = row_q;
    assign bus.tile_col  = col_q;
    assign bus.tile_done = tile_done_q;

`ifdef MM_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            cyc_q <= '0;
        end else if (busy_q) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign bus.cycle_count = cyc_q;
`endif

endmodule

`default_nettype wire
